// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
// Any block fronting the shared signed divider imports this package.
package div_arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;

  // Widest operand the divide-by-zero quotient pattern covers.
  localparam int MAX_WIDTH = 64;

  // Quotient reported for divide-by-zero: all ones.
  localparam logic [MAX_WIDTH-1:0] DZ_COC = {MAX_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Increment a requester index, wrapping back to zero after n-1.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/div_share_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping modulo NREQ. Reusable in front of any shared resource.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);

  // Index ptr+k, folded back into 0..NREQ-1.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return (s >= NREQ) ? IDW'(s - NREQ) : IDW'(s);
  endfunction

  // Winner search: offsets are scanned downward so the smallest offset wins.
  always_comb begin
    id  = {IDW{1'b0}};
    any = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      id = req[wrap_add(ptr, k)] ? wrap_add(ptr, k) : id;
    end
  end

  // One-hot grant decoded from the winner id.
  always_comb begin
    gnt = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = any && (id == IDW'(i));
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin front end sharing one sequential signed divider among NREQ
// requesters, with local divide-by-zero trapping and a tagged response channel.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RSTa,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_num,
  input  logic [NREQ*WIDTH-1:0] req_den,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_coc,
  output logic [WIDTH-1:0]      rsp_res,
  output logic                  rsp_dz,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_num,
  output logic [WIDTH-1:0]      div_den,
  input  logic [WIDTH-1:0]      div_coc,
  input  logic [WIDTH-1:0]      div_res,
  input  logic                  div_done
);

  arb_state_t       state_r;
  arb_state_t       state_s;
  logic [IDW-1:0]   rr_ptr_r;
  logic [IDW-1:0]   id_r;
  logic [WIDTH-1:0] num_r;
  logic [WIDTH-1:0] den_r;
  logic [WIDTH-1:0] coc_r;
  logic [WIDTH-1:0] res_r;
  logic             dz_r;

  logic [NREQ-1:0]  pick_gnt_s;
  logic [IDW-1:0]   pick_id_s;
  logic             pick_any_s;
  logic [WIDTH-1:0] sel_num_s;
  logic [WIDTH-1:0] sel_den_s;
  logic             sel_dz_s;
  logic             grant_s;
  logic             rsp_hs_s;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .gnt (pick_gnt_s),
    .id  (pick_id_s),
    .any (pick_any_s)
  );

  // Operand mux for the current winner plus the divide-by-zero trap.
  always_comb begin
    sel_num_s = {WIDTH{1'b0}};
    sel_den_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_num_s = (pick_id_s == IDW'(i)) ? req_num[i*WIDTH +: WIDTH] : sel_num_s;
      sel_den_s = (pick_id_s == IDW'(i)) ? req_den[i*WIDTH +: WIDTH] : sel_den_s;
    end
    sel_dz_s = (sel_den_s == {WIDTH{1'b0}});
  end

  assign grant_s  = (state_r == IDLE) && pick_any_s;
  assign rsp_hs_s = (state_r == RESP) && rsp_ready;

  // State register.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a zero divisor bypasses the divider entirely.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_s = sel_dz_s ? RESP : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (div_done) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Moore-style controls; the accept strobe is held off while reset is applied.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    div_start = 1'b0;
    rsp_valid = 1'b0;
    case (state_r)
      IDLE:    req_ready = RSTa ? pick_gnt_s : {NREQ{1'b0}};
      ISSUE:   div_start = 1'b1;
      WAIT:    div_start = 1'b0;
      RESP:    rsp_valid = 1'b1;
      default: rsp_valid = 1'b0;
    endcase
  end

  // Operand and result latches, plus the round-robin pointer.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      rr_ptr_r <= {IDW{1'b0}};
      id_r     <= {IDW{1'b0}};
      num_r    <= {WIDTH{1'b0}};
      den_r    <= {WIDTH{1'b0}};
      coc_r    <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      dz_r     <= 1'b0;
    end else begin
      if (grant_s) begin
        id_r  <= pick_id_s;
        num_r <= sel_num_s;
        den_r <= sel_den_s;
        dz_r  <= sel_dz_s;
        if (sel_dz_s) begin
          coc_r <= DZ_COC[WIDTH-1:0];
          res_r <= sel_num_s;
        end
      end else if ((state_r == WAIT) && div_done) begin
        coc_r <= div_coc;
        res_r <= div_res;
        dz_r  <= 1'b0;
      end
      if (rsp_hs_s) begin
        rr_ptr_r <= IDW'(wrap_inc(int'(id_r), NREQ));
      end
    end
  end

  assign rsp_id  = id_r;
  assign rsp_coc = coc_r;
  assign rsp_res = res_r;
  assign rsp_dz  = dz_r;
  assign div_num = num_r;
  assign div_den = den_r;

endmodule
